// File: rtl/attn_pkg.sv
// Shared types and constants for the attention score generator.
package attn_pkg;

    localparam int SCORE_W = 32;

    typedef logic signed [SCORE_W-1:0] score_t;

    localparam score_t SCORE_MAX = 32'sh7fff_ffff;
    localparam score_t SCORE_MIN = 32'sh8000_0000;

    typedef enum logic {
        ACCUM,
        EMIT
    } attn_state_t;

endpackage

// File: rtl/attn_mac.sv
// Multiply-accumulate for one dot product, with arithmetic-shift scaling and
// saturation of (acc + a*b) to a 32-bit signed score.
module attn_mac
    import attn_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DIM   = 16,
    parameter int SHIFT = 2,
    parameter int AW    = 2*DW + $clog2(DIM) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_after,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [AW-1:0] acc_o,
    output score_t               sat_o
);

    localparam int MW = (AW > SCORE_W) ? AW : SCORE_W + 1;

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   shifted;
    logic signed [MW-1:0]   wide;

    assign prod    = (2*DW)'(a) * (2*DW)'(b);
    assign sum     = acc_o + AW'(prod);
    assign shifted = sum >>> SHIFT;
    assign wide    = MW'(shifted);

    always_comb begin
        sat_o = wide[SCORE_W-1:0];
        if (wide > MW'(SCORE_MAX)) begin
            sat_o = SCORE_MAX;
        end else if (wide < MW'(SCORE_MIN)) begin
            sat_o = SCORE_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_o <= '0;
        end else if (en) begin
            acc_o <= clr_after ? '0 : sum;
        end
    end

endmodule

// File: rtl/attn_score_gen.sv
// Streams q/k element pairs, produces LEN scaled+saturated dot-product scores
// and pulses valid_out once per vector. Optional causal mask: ATTN_CAUSAL_MASK_EN.
module attn_score_gen
    import attn_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int DIM   = 16,
    parameter int DW    = 16,
    parameter int SHIFT = 2,
    localparam int KW   = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ATTN_CAUSAL_MASK_EN
    input  logic [KW-1:0]        q_pos,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] q_data,
    input  logic signed [DW-1:0] k_data,
    output logic                 valid_out,
    output score_t               scores [LEN]
);

    localparam int EW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int AW = 2*DW + $clog2(DIM) + 1;
    localparam logic [EW-1:0] ELEM_LAST = EW'(DIM - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(LEN - 1);

    attn_state_t          state, state_nx;
    logic [EW-1:0]        elem_cnt;
    logic [KW-1:0]        key_cnt;
    logic                 xfer;
    logic                 last_elem;
    logic                 last_key;
    score_t               mac_sat;
    score_t               wr_score;
    logic signed [AW-1:0] acc_unused;

    assign last_elem = (elem_cnt == ELEM_LAST);
    assign last_key  = (key_cnt == KEY_LAST);

    attn_mac #(
        .DW   (DW),
        .DIM  (DIM),
        .SHIFT(SHIFT),
        .AW   (AW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en       (xfer),
        .clr_after(last_elem),
        .a        (q_data),
        .b        (k_data),
        .acc_o    (acc_unused),
        .sat_o    (mac_sat)
    );

`ifdef ATTN_CAUSAL_MASK_EN
    // Future keys get the most negative score so softmax drives them to ~0.
    assign wr_score = (key_cnt > q_pos) ? SCORE_MIN : mac_sat;
`else
    assign wr_score = mac_sat;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        valid_out = 1'b0;
        xfer      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (in_valid && last_elem && last_key) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                valid_out = 1'b1;
                state_nx  = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            elem_cnt <= '0;
            key_cnt  <= '0;
            scores   <= '{default: '0};
        end else begin
            state <= state_nx;
            if (xfer) begin
                if (last_elem) begin
                    elem_cnt         <= '0;
                    scores[key_cnt]  <= wr_score;
                    key_cnt          <= last_key ? '0 : key_cnt + KW'(1);
                end else begin
                    elem_cnt <= elem_cnt + EW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_attn_score_gen.sv
// Scoreboard bench: two DUTs (SHIFT=0 and SHIFT=2) share one input stream and
// are checked against a plain-arithmetic dot-product reference model.
module tb_attn_score_gen;

    localparam int LEN = 8;
    localparam int DIM = 4;
    localparam int DW  = 16;
    localparam int SH0 = 0;
    localparam int SH1 = 2;
`ifdef ATTN_CAUSAL_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    typedef logic [LEN*32-1:0] vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] q_data;
    logic signed [DW-1:0] k_data;
    logic [2:0]           q_pos;
    logic                 in_ready0, in_ready1;
    logic                 valid_out0, valid_out1;
    logic signed [31:0]   scores0 [LEN];
    logic signed [31:0]   scores1 [LEN];

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int pushed     = 0;
    int cyc        = 0;

    vec_t exp0[$];
    vec_t exp1[$];
    int   due_q[$];

    logic signed [DW-1:0] qv [LEN][DIM];
    logic signed [DW-1:0] kv [LEN][DIM];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    attn_score_gen #(.LEN(LEN), .DIM(DIM), .DW(DW), .SHIFT(SH0)) dut0 (
`ifdef ATTN_CAUSAL_MASK_EN
        .q_pos    (q_pos),
`endif
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .q_data   (q_data),
        .k_data   (k_data),
        .valid_out(valid_out0),
        .scores   (scores0)
    );

    attn_score_gen #(.LEN(LEN), .DIM(DIM), .DW(DW), .SHIFT(SH1)) dut1 (
`ifdef ATTN_CAUSAL_MASK_EN
        .q_pos    (q_pos),
`endif
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .q_data   (q_data),
        .k_data   (k_data),
        .valid_out(valid_out1),
        .scores   (scores1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_score(input longint dot, input int sh,
                                              input int key, input int qp);
        longint s;
        if (MASK && key > qp) return 32'h8000_0000;
        s = dot >>> sh;
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < LEN; i++) begin
            for (int e = 0; e < DIM; e++) begin
                case (mode)
                    0: begin qv[i][e] = 16'(e + 1); kv[i][e] = 16'(e + 1); end
                    1: begin qv[i][e] = (e == 0) ? 16'(i) : 16'sd0;
                             kv[i][e] = (e == 0) ? 16'sd4 : 16'sd0; end
                    2: begin qv[i][e] = (e == 0) ? -16'sd3 : 16'sd0;
                             kv[i][e] = (e == 0) ? 16'sd1 : 16'sd0; end
                    3: begin qv[i][e] = 16'sh8000; kv[i][e] = 16'sh8000; end
                    4: begin qv[i][e] = 16'sh8000; kv[i][e] = 16'sh7fff; end
                    default: begin qv[i][e] = 16'($urandom); kv[i][e] = 16'($urandom); end
                endcase
            end
        end
    endtask

    // One element pair; retries until accepted, optionally idling with in_valid low.
    task automatic xfer(input logic signed [DW-1:0] q, input logic signed [DW-1:0] k,
                        input int stall_pct);
        bit done = 1'b0;
        bit ok;
        int guard = 0;
        while (!done) begin
            @(negedge clk);
            if ($urandom_range(99) < stall_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                in_valid = 1'b1;
                q_data   = q;
                k_data   = k;
                ok       = in_ready0;
                @(posedge clk); #1;
                if (ok) done = 1'b1;
            end
            guard++;
            if (!done && guard > 64) begin
                compared++;
                mismatched++;
                $display("FAIL accept_timeout: got in_ready stuck low, expected acceptance");
                done = 1'b1;
            end
        end
    endtask

    task automatic drive_vec(input int stall_pct, input int limit, input logic [2:0] qp);
        int n = 0;
        vec_t e0, e1;
        longint dot;
        q_pos = qp;
        for (int i = 0; i < LEN; i++) begin
            for (int e = 0; e < DIM; e++) begin
                if (n == limit) return;
                xfer(qv[i][e], kv[i][e], stall_pct);
                n++;
            end
        end
        for (int i = 0; i < LEN; i++) begin
            dot = 0;
            for (int e = 0; e < DIM; e++) dot += longint'(qv[i][e]) * longint'(kv[i][e]);
            e0[i*32 +: 32] = ref_score(dot, SH0, i, int'(qp));
            e1[i*32 +: 32] = ref_score(dot, SH1, i, int'(qp));
        end
        exp0.push_back(e0);
        exp1.push_back(e1);
        due_q.push_back(cyc);
        pushed++;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready0"}, in_ready0, 1);
        chk({tag, "_ready1"}, in_ready1, 1);
        chk({tag, "_valid0"}, valid_out0, 0);
        chk({tag, "_valid1"}, valid_out1, 0);
        for (int i = 0; i < LEN; i++) begin
            chk($sformatf("%s_s0[%0d]", tag, i), scores0[i], 0);
            chk($sformatf("%s_s1[%0d]", tag, i), scores1[i], 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_low_only_in_emit", in_ready0, !valid_out0);
            chk("ready_dut1", in_ready1, in_ready0);
            chk("pulse_align", valid_out1, valid_out0);
            if (valid_out0) begin
                pulses++;
                if (exp0.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_pulse: got valid_out=1, expected no vector pending");
                end else begin
                    automatic vec_t e0 = exp0.pop_front();
                    automatic vec_t e1 = exp1.pop_front();
                    automatic int due  = due_q.pop_front();
                    chk("latency_cycle", cyc, due);
                    for (int i = 0; i < LEN; i++) begin
                        chk($sformatf("sh0_score[%0d]", i), scores0[i], $signed(e0[i*32 +: 32]));
                        chk($sformatf("sh2_score[%0d]", i), scores1[i], $signed(e1[i*32 +: 32]));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        q_data = '0;
        k_data = '0;
        q_pos = 3'd7;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        fill(0); drive_vec(0, LEN*DIM, 3'd2);
        fill(0); drive_vec(0, LEN*DIM, 3'd7);
        fill(1); drive_vec(0, LEN*DIM, 3'd7);
        fill(2); drive_vec(0, LEN*DIM, 3'd5);
        fill(3); drive_vec(0, LEN*DIM, 3'd7);
        fill(4); drive_vec(0, LEN*DIM, 3'd0);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Partial vector then reset: nothing from the 13 transfers may surface.
        fill(5); drive_vec(0, 13, 3'd7);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_reset_state("midreset");
        fill(5); drive_vec(0, LEN*DIM, 3'd7);

        fill(0); drive_vec(50, LEN*DIM, 3'd7);
        for (int v = 0; v < 6; v++) begin
            fill(5);
            drive_vec(50, LEN*DIM, 3'($urandom_range(7)));
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (6) @(negedge clk);

        chk("leftover_vectors", exp0.size(), 0);
        chk("pulse_count", pulses, pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
